line_mem_responder: RTL and testbench

Word-organised main-memory responder serving the memory port of the cache memory translator. It returns 256-bit cache lines for line-read requests and commits byte-strobed 32-bit writes. It uses a single-port synchronous word RAM and sits on the memory side of the translator, opposite the initiator state machine. The block is the FPGA-synthesisable replacement for the single-cycle behavioural memory.

---
 rtl/line_mem_responder_pkg.sv | 21 ++
 rtl/line_mem_responder_word_ram_be.sv | 37 +++
 rtl/line_mem_responder.sv | 141 ++++++++++++++
 tb/tb_line_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared constants and FSM state encoding for the line memory responder.
package line_mem_responder_pkg;

   localparam int unsigned LINE_WORDS       = 8;
   localparam int unsigned WORD_OFFSET_BITS = 2;
   localparam int unsigned LINE_OFFSET_BITS = 5;

   // Slot index within a line, and a beat counter that can also hold LINE_WORDS
   localparam int unsigned SLOT_BITS = $clog2(LINE_WORDS);
   localparam int unsigned BEAT_BITS = SLOT_BITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DONE,
      WR,
      WR_DONE,
      RELEASE
   } state_t;

endpackage

// File: rtl/line_mem_responder_word_ram_be.sv
// Single-port synchronous word RAM with per-byte write enables and a
// one-cycle registered read (read-first), shaped for block RAM inference.
module word_ram_be
  import line_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4096,
  parameter string       INIT_FILE  = ""
) (
  input  logic                      i_clk,
  input  logic                      i_en,
  input  logic                      i_we,
  input  logic [DATA_WIDTH/8-1:0]   i_be,
  input  logic [$clog2(DEPTH)-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-enabled write and registered read of the addressed word
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
          if (i_be[b]) begin
            mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end
      o_rdata <= mem[i_addr];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder: serves 256-bit line reads as eight sequential word
// reads from a single-port RAM and commits byte-strobed single-word writes.
module line_mem_responder
   import line_mem_responder_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned CACHE_LINE_WIDTH = 256,
   parameter int unsigned MEM_DEPTH_WORDS  = 4096,
   parameter string       INIT_FILE        = ""
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [ADDR_WIDTH-1:0]       i_mem_read_address,
   input  logic                        i_mem_read_req,
   output logic                        o_mem_read_done,
   output logic [CACHE_LINE_WIDTH-1:0] o_cache_line,
   input  logic                        i_mem_write_valid,
   input  logic [DATA_WIDTH-1:0]       i_mem_write_data,
   input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
   input  logic [7:0]                  i_write_strobe,
   output logic                        o_mem_write_done
);

   localparam int unsigned RAM_AW     = $clog2(MEM_DEPTH_WORDS);
   localparam int unsigned LINE_IDX_W = RAM_AW - SLOT_BITS;
   localparam logic [BEAT_BITS-1:0] BEAT_LAST = BEAT_BITS'(LINE_WORDS);

   state_t                  state;
   logic [BEAT_BITS-1:0]    beat;
   logic [LINE_IDX_W-1:0]   line_idx;
   logic [RAM_AW-1:0]       wr_word;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [3:0]              wr_be;

   logic                    ram_en;
   logic                    ram_we;
   logic [RAM_AW-1:0]       ram_addr;
   logic [DATA_WIDTH-1:0]   ram_rdata;
   logic [SLOT_BITS-1:0]    slot;

   // Address bits below the word/line offset and strobe[7:4] carry no meaning here
   logic unused_bits;
   assign unused_bits = ^{i_write_strobe[7:4], i_mem_read_address, i_mem_write_address};

   // RAM port steering: the write word in WR, otherwise the current read beat
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = {line_idx, beat[SLOT_BITS-1:0]};
      if (state == WR) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = wr_word;
      end else if (state == RD && beat != BEAT_LAST) begin
         ram_en = 1'b1;
      end
   end

   // Read data returned now belongs to the beat issued one cycle earlier
   always_comb begin
      slot = beat[SLOT_BITS-1:0] - SLOT_BITS'(1);
   end

   word_ram_be #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH_WORDS),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .i_clk   (i_clk),
      .i_en    (ram_en),
      .i_we    (ram_we),
      .i_be    (wr_be),
      .i_addr  (ram_addr),
      .i_wdata (wr_data),
      .o_rdata (ram_rdata)
   );

   // Control FSM with beat counter, line assembly and registered done pulses
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state            <= IDLE;
         beat             <= '0;
         line_idx         <= '0;
         wr_word          <= '0;
         wr_data          <= '0;
         wr_be            <= '0;
         o_mem_read_done  <= 1'b0;
         o_mem_write_done <= 1'b0;
         o_cache_line     <= '0;
      end else begin
         o_mem_read_done  <= 1'b0;
         o_mem_write_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_mem_write_valid) begin
                  wr_word <= i_mem_write_address[WORD_OFFSET_BITS +: RAM_AW];
                  wr_data <= i_mem_write_data;
                  wr_be   <= i_write_strobe[3:0];
                  state   <= WR;
               end else if (i_mem_read_req) begin
                  line_idx <= i_mem_read_address[LINE_OFFSET_BITS +: LINE_IDX_W];
                  beat     <= '0;
                  state    <= RD;
               end
            end
            // Issue and capture overlap: beat k is issued while beat k-1 lands
            RD: begin
               if (beat != '0) begin
                  o_cache_line[slot*DATA_WIDTH +: DATA_WIDTH] <= ram_rdata;
               end
               if (beat == BEAT_LAST) begin
                  o_mem_read_done <= 1'b1;
                  state           <= RD_DONE;
               end else begin
                  beat <= beat + BEAT_BITS'(1);
               end
            end
            RD_DONE: begin
               state <= RELEASE;
            end
            WR: begin
               o_mem_write_done <= 1'b1;
               state            <= WR_DONE;
            end
            WR_DONE: begin
               state <= RELEASE;
            end
            RELEASE: begin
               if (!i_mem_read_req && !i_mem_write_valid) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: a word-level memory model feeds
// a queue of expected lines that is popped when the DUT signals read done.
module tb_line_mem_responder;

   logic         i_clk;
   logic         i_rst_n;
   logic [31:0]  i_mem_read_address;
   logic         i_mem_read_req;
   logic         o_mem_read_done;
   logic [255:0] o_cache_line;
   logic         i_mem_write_valid;
   logic [31:0]  i_mem_write_data;
   logic [31:0]  i_mem_write_address;
   logic [7:0]   i_write_strobe;
   logic         o_mem_write_done;

   int checks = 0;
   int errors = 0;

   logic [31:0]  model [4096];
   logic [255:0] sb [$];

   line_mem_responder #(
      .DATA_WIDTH       (32),
      .ADDR_WIDTH       (32),
      .CACHE_LINE_WIDTH (256),
      .MEM_DEPTH_WORDS  (4096),
      .INIT_FILE        ("")
   ) dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_mem_read_address  (i_mem_read_address),
      .i_mem_read_req      (i_mem_read_req),
      .o_mem_read_done     (o_mem_read_done),
      .o_cache_line        (o_cache_line),
      .i_mem_write_valid   (i_mem_write_valid),
      .i_mem_write_data    (i_mem_write_data),
      .i_mem_write_address (i_mem_write_address),
      .i_write_strobe      (i_write_strobe),
      .o_mem_write_done    (o_mem_write_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #400000;
      $display("FAIL watchdog: actual=time limit reached required=bench completion");
      $fatal(1);
   end

   function automatic logic [255:0] model_line(input logic [31:0] addr);
      logic [255:0] l;
      int unsigned  base;
      base = ((addr >> 2) % 4096) & ~32'd7;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = model[(base + i) % 4096];
      return l;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
      int unsigned idx;
      idx = (addr >> 2) % 4096;
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
   endtask

   // Drives one line read; lat = posedges to done (0 on timeout), extra = later read-done pulses
   task automatic run_read(input logic [31:0] addr, input int hold,
                           output int lat, output logic [255:0] line, output int extra);
      lat = 0; extra = 0; line = '0;
      i_mem_read_address = addr;
      i_mem_read_req     = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) begin
            lat  = i;
            line = o_cache_line;
            break;
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) extra++;
      end
      i_mem_read_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) extra++;
      end
   endtask

   // Drives one word write and updates the model; lat = posedges to done (0 on timeout)
   task automatic run_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                            output int lat, output int extra);
      lat = 0; extra = 0;
      model_write(addr, data, strb);
      i_mem_write_address = addr;
      i_mem_write_data    = data;
      i_write_strobe      = strb;
      i_mem_write_valid   = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_write_done) begin
            lat = i;
            break;
         end
      end
      i_mem_write_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_write_done) extra++;
      end
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_mem_read_req = 1'b0; i_mem_write_valid = 1'b0;
      i_mem_read_address = '0; i_mem_write_address = '0;
      i_mem_write_data = '0; i_write_strobe = '0;
      repeat (3) @(negedge i_clk);
      checks++; if (o_mem_read_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b want 0", o_mem_read_done); end
      checks++; if (o_mem_write_done !== 1'b0) begin errors++; $display("FAIL reset_wr_done: got %b want 0", o_mem_write_done); end
      checks++; if (o_cache_line !== 256'd0) begin errors++; $display("FAIL reset_line: got %h want 0", o_cache_line); end
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      checks++; if ({o_mem_read_done, o_mem_write_done} !== 2'b00) begin errors++; $display("FAIL reset_idle_done: got %b want 00", {o_mem_read_done, o_mem_write_done}); end
   endtask

   task automatic test_preload();
      int lat, extra;
      for (int i = 0; i < 16; i++) begin
         run_write(32'(i * 4), 32'h1000_0000 + 32'(i), 8'h0F, lat, extra);
         checks++; if (lat != 2 || extra != 0) begin errors++; $display("FAIL preload_wr_lat[%0d]: got lat=%0d extra=%0d want lat=2 extra=0", i, lat, extra); end
      end
   endtask

   task automatic test_read_basic();
      int lat, extra;
      logic [255:0] line, exp;
      sb.push_back(model_line(32'h0));
      run_read(32'h0, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp) begin errors++; $display("FAIL basic_line: got %h want %h", line, exp); end
      checks++; if (lat != 10) begin errors++; $display("FAIL basic_lat: got %0d want 10", lat); end
      checks++; if (extra != 0) begin errors++; $display("FAIL basic_pulse_width: got %0d extra pulses want 0", extra); end
      checks++; if (line[31:0] !== 32'h1000_0000) begin errors++; $display("FAIL basic_word0: got %h want 10000000", line[31:0]); end
      checks++; if (line[255:224] !== 32'h1000_0007) begin errors++; $display("FAIL basic_word7: got %h want 10000007", line[255:224]); end
   endtask

   task automatic test_write_strobe();
      int lat, extra;
      logic [255:0] line, exp;
      // strobe[7:4] set on purpose: those bits must have no effect
      run_write(32'h24, 32'hDEAD_BEEF, 8'hA5, lat, extra);
      checks++; if (lat != 2 || extra != 0) begin errors++; $display("FAIL strobe_wr_lat: got lat=%0d extra=%0d want lat=2 extra=0", lat, extra); end
      sb.push_back(model_line(32'h20));
      run_read(32'h20, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp) begin errors++; $display("FAIL strobe_line: got %h want %h", line, exp); end
      checks++; if (line[63:32] !== 32'h10AD_00EF) begin errors++; $display("FAIL strobe_word1: got %h want 10ad00ef", line[63:32]); end
      // Zero strobe still completes but leaves the word untouched
      run_write(32'h2C, 32'hFFFF_FFFF, 8'h00, lat, extra);
      checks++; if (lat != 2 || extra != 0) begin errors++; $display("FAIL zero_strobe_lat: got lat=%0d extra=%0d want lat=2 extra=0", lat, extra); end
      sb.push_back(model_line(32'h20));
      run_read(32'h20, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp || lat != 10) begin errors++; $display("FAIL zero_strobe_line: got %h lat=%0d want %h lat=10", line, lat, exp); end
   endtask

   task automatic test_simultaneous();
      int wlat, lat, extra;
      bit rd_early;
      logic [255:0] line, exp;
      wlat = 0; rd_early = 1'b0;
      model_write(32'h08, 32'hCAFE_F00D, 8'h0F);
      i_mem_write_address = 32'h08; i_mem_write_data = 32'hCAFE_F00D; i_write_strobe = 8'h0F;
      i_mem_read_address  = 32'h00;
      i_mem_write_valid = 1'b1; i_mem_read_req = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) rd_early = 1'b1;
         if (o_mem_write_done) begin wlat = i; break; end
      end
      i_mem_write_valid = 1'b0; i_mem_read_req = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      checks++; if (wlat != 2) begin errors++; $display("FAIL simul_wr_first_lat: got %0d want 2", wlat); end
      checks++; if (rd_early !== 1'b0) begin errors++; $display("FAIL simul_rd_before_wr: got %b want 0", rd_early); end
      sb.push_back(model_line(32'h0));
      run_read(32'h0, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp || lat != 10) begin errors++; $display("FAIL simul_rd_line: got %h lat=%0d want %h lat=10", line, lat, exp); end
      checks++; if (line[95:64] !== 32'hCAFE_F00D) begin errors++; $display("FAIL simul_word2: got %h want cafef00d", line[95:64]); end
   endtask

   task automatic test_held_req();
      int lat, extra;
      logic [255:0] line, exp;
      sb.push_back(model_line(32'h20));
      run_read(32'h20, 5, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (lat != 10 || line !== exp) begin errors++; $display("FAIL held_first: got lat=%0d %h want lat=10 %h", lat, line, exp); end
      checks++; if (extra != 0) begin errors++; $display("FAIL held_retrigger: got %0d extra pulses want 0", extra); end
      sb.push_back(model_line(32'h0));
      run_read(32'h0, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (lat != 10 || line !== exp) begin errors++; $display("FAIL held_next: got lat=%0d %h want lat=10 %h", lat, line, exp); end
   endtask

   task automatic test_wrap();
      int lat, extra;
      logic [255:0] line, exp;
      sb.push_back(model_line(32'h0001_0020));
      run_read(32'h0001_0020, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp || lat != 10) begin errors++; $display("FAIL wrap_line: got %h lat=%0d want %h lat=10", line, lat, exp); end
      checks++; if (line[63:32] !== 32'h10AD_00EF) begin errors++; $display("FAIL wrap_word1: got %h want 10ad00ef", line[63:32]); end
   endtask

   task automatic test_reset_mid_read();
      int lat, extra;
      bit seen;
      logic [255:0] line, exp;
      seen = 1'b0;
      i_mem_read_address = 32'h20;
      i_mem_read_req     = 1'b1;
      repeat (5) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) seen = 1'b1;
      end
      i_rst_n = 1'b0;
      i_mem_read_req = 1'b0;
      #1;
      checks++; if ({o_mem_read_done, o_mem_write_done} !== 2'b00 || o_cache_line !== 256'd0) begin
         errors++; $display("FAIL midrst_outputs: got rd=%b wr=%b line=%h want 0 0 0", o_mem_read_done, o_mem_write_done, o_cache_line);
      end
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (12) begin
         @(posedge i_clk); #1;
         if (o_mem_read_done) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", seen); end
      sb.push_back(model_line(32'h0));
      run_read(32'h0, 0, lat, line, extra);
      exp = sb.pop_front();
      checks++; if (line !== exp || lat != 10) begin errors++; $display("FAIL midrst_recover: got %h lat=%0d want %h lat=10", line, lat, exp); end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_read_basic();
      test_write_strobe();
      test_simultaneous();
      test_held_req();
      test_wrap();
      test_reset_mid_read();
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
